// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin two-requester arbiter sequencing one memory access with wait states
module mem_bus_arbiter #(
  parameter int WAIT_STATES = 1
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ack,
  output logic [7:0]  cpu_rdata,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [15:0] dma_addr,
  input  logic [7:0]  dma_wdata,
  output logic        dma_ack,
  output logic [7:0]  dma_rdata,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_enable,
  output logic        busy,
  output logic        owner
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t state, state_n;
  logic [3:0] cnt;
  logic we_l, last_owner, grant_dma, start, owner_n, we_n;
  // Arbitration and next state; outputs are registered from these next values
  always_comb begin
    grant_dma = dma_req & (~cpu_req | ~last_owner);
    start = (state == IDLE) & (cpu_req | dma_req);
    owner_n = start ? grant_dma : owner;
    we_n = start ? (grant_dma ? dma_we : cpu_we) : we_l;
    state_n = start ? ACCESS : (state == ACCESS) ? ((cnt == 4'd0) ? DONE : ACCESS) : IDLE;
  end
  // State, latched request, registered bus strobes, acks and read data
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state <= IDLE;
      cnt <= 4'd0;
      we_l <= 1'b0;
      owner <= 1'b0;
      last_owner <= 1'b1;
      mem_addr <= 16'h0000;
      mem_wdata <= 8'h00;
      mem_enable <= 1'b0;
      mem_read <= 1'b0;
      mem_write <= 1'b0;
      busy <= 1'b0;
      cpu_ack <= 1'b0;
      dma_ack <= 1'b0;
      cpu_rdata <= 8'h00;
      dma_rdata <= 8'h00;
    end else begin
      state <= state_n;
      owner <= owner_n;
      we_l <= we_n;
      cnt <= (state == ACCESS) ? cnt - 4'd1 : 4'(WAIT_STATES);
      if (start) begin
        mem_addr <= grant_dma ? dma_addr : cpu_addr;
        mem_wdata <= grant_dma ? dma_wdata : cpu_wdata;
      end
      mem_enable <= state_n == ACCESS;
      mem_read <= (state_n == ACCESS) & ~we_n;
      mem_write <= (state_n == ACCESS) & we_n;
      busy <= state_n != IDLE;
      cpu_ack <= (state_n == DONE) & ~owner_n;
      dma_ack <= (state_n == DONE) & owner_n;
      if (state == ACCESS && cnt == 4'd0 && !we_l) begin
        if (owner) dma_rdata <= mem_rdata;
        else cpu_rdata <= mem_rdata;
      end
      if (state == DONE) last_owner <= owner;
    end
  end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: random and directed stimulus checked against a transaction-phase reference model
module tb_mem_bus_arbiter;
  localparam int W = 1;
  logic clk_in = 1'b0;
  logic reset = 1'b1;
  logic cpu_req = 1'b0, cpu_we = 1'b0, dma_req = 1'b0, dma_we = 1'b0;
  logic [15:0] cpu_addr = 16'h0, dma_addr = 16'h0;
  logic [7:0] cpu_wdata = 8'h0, dma_wdata = 8'h0;
  logic cpu_ack, dma_ack, mem_read, mem_write, mem_enable, busy, owner;
  logic [7:0] cpu_rdata, dma_rdata, mem_wdata, mem_rdata;
  logic [15:0] mem_addr;
  logic [7:0] mem [0:65535];
  logic [7:0] ref_mem [0:65535];
  int n_vec = 0, n_err = 0;
  int ph = 0;
  logic eo = 1'b0, ewe = 1'b0, last = 1'b1, rst_last = 1'b1;
  logic [15:0] ea = 16'h0;
  logic [7:0] ed = 8'h0, ecr = 8'h0, edr = 8'h0;

  mem_bus_arbiter #(.WAIT_STATES(W)) dut (
    .clk_in(clk_in), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_ack(dma_ack), .dma_rdata(dma_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_enable(mem_enable),
    .busy(busy), .owner(owner)
  );

  assign mem_rdata = mem[mem_addr];
  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // One cycle: compare outputs with the model, let memory see the bus, drive inputs, advance the model
  task automatic step(input logic r, input logic cr, input logic cw, input logic [15:0] ca,
                      input logic [7:0] cd, input logic dr, input logic dw, input logic [15:0] da,
                      input logic [7:0] dd);
    logic en;
    @(negedge clk_in);
    en = ph >= 1 && ph <= W + 1;
    check("busy", 16'(busy), 16'(ph != 0));
    check("mem_enable", 16'(mem_enable), 16'(en));
    check("mem_read", 16'(mem_read), 16'(en && !ewe));
    check("mem_write", 16'(mem_write), 16'(en && ewe));
    check("cpu_ack", 16'(cpu_ack), 16'(ph == W + 2 && !eo));
    check("dma_ack", 16'(dma_ack), 16'(ph == W + 2 && eo));
    check("cpu_rdata", 16'(cpu_rdata), 16'(ecr));
    check("dma_rdata", 16'(dma_rdata), 16'(edr));
    if (ph != 0) check("owner", 16'(owner), 16'(eo));
    if (en) begin
      check("mem_addr", mem_addr, ea);
      check("mem_wdata", 16'(mem_wdata), 16'(ed));
    end
    if (rst_last) begin
      check("rst_owner", 16'(owner), 16'h0);
      check("rst_addr", mem_addr, 16'h0);
      check("rst_wdata", 16'(mem_wdata), 16'h0);
    end
    if (mem_enable && mem_write) mem[mem_addr] = mem_wdata;
    if (en && ewe) ref_mem[ea] = ed;
    reset = r;
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    dma_req = dr; dma_we = dw; dma_addr = da; dma_wdata = dd;
    if (r) begin
      ph = 0; last = 1'b1; ecr = 8'h0; edr = 8'h0; rst_last = 1'b1;
    end else begin
      rst_last = 1'b0;
      if (ph == 0) begin
        if (cr || dr) begin
          eo = (cr && dr) ? !last : dr;
          ewe = eo ? dw : cw;
          ea = eo ? da : ca;
          ed = eo ? dd : cd;
          ph = 1;
        end
      end else if (ph == W + 2) begin
        last = eo;
        ph = 0;
      end else begin
        if (ph == W + 1 && !ewe) begin
          if (eo) edr = ref_mem[ea];
          else ecr = ref_mem[ea];
        end
        ph++;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      mem[i] = 8'(i * 7 + 3);
      ref_mem[i] = mem[i];
    end
    mem[0] = 8'hA0; ref_mem[0] = 8'hA0;
    mem[1] = 8'hFF; ref_mem[1] = 8'hFF;
    @(posedge clk_in);
    repeat (2) step(1, 1, 0, 16'h0000, 8'h00, 1, 1, 16'h1234, 8'h55);
    repeat (2 * (W + 3)) step(0, 1, 0, 16'h0000, 8'h00, 1, 1, 16'h1234, 8'h55);
    repeat (3) step(0, 0, 0, 16'h0000, 8'h00, 0, 0, 16'h0000, 8'h00);
    check("peek_1234", 16'(mem[16'h1234]), 16'h0055);
    for (int i = 0; i < 4 * (W + 3); i++)
      step(0, 1, 0, 16'($urandom_range(0, 7)), 8'h00, 1, 0, 16'($urandom_range(0, 7)), 8'h00);
    repeat (3) step(0, 0, 0, 16'h0000, 8'h00, 0, 0, 16'h0000, 8'h00);
    step(0, 0, 0, 16'h0000, 8'h00, 1, 0, 16'h0001, 8'h00);
    step(0, 0, 0, 16'h0000, 8'h00, 0, 0, 16'h0000, 8'h00);
    step(1, 0, 0, 16'h0000, 8'h00, 0, 0, 16'h0000, 8'h00);
    step(1, 1, 0, 16'h0002, 8'h00, 1, 0, 16'h0003, 8'h00);
    repeat (W + 3) step(0, 1, 0, 16'h0002, 8'h00, 1, 0, 16'h0003, 8'h00);
    repeat (W + 3) step(0, 0, 0, 16'h0000, 8'h00, 0, 0, 16'h0000, 8'h00);
    repeat (W + 3) step(0, 1, 0, 16'h0000, 8'h00, 0, 0, 16'h0000, 8'h00);
    repeat (W + 3) step(0, 1, 0, 16'h0001, 8'h00, 0, 0, 16'h0000, 8'h00);
    repeat (3) step(0, 0, 0, 16'h0000, 8'h00, 0, 0, 16'h0000, 8'h00);
    for (int i = 0; i < 1500; i++)
      step(($urandom_range(0, 63) == 0), 1'($urandom), 1'($urandom), 16'($urandom_range(0, 7)),
           8'($urandom), 1'($urandom), 1'($urandom), 16'($urandom_range(0, 7)), 8'($urandom));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
